// File: rtl/npu_axi_mem_router.sv
// npu_axi_mem_router: behavioural AXI4-subset slave memory for NPU shell simulation.
// Every AXI address is folded onto the byte array "mem" by its low MEM_ADDR_W bits.
// Independent single-outstanding INCR write and read bursts; responses are always OKAY.
// Optional macro AXI_MEM_INIT_PATTERN_EN: preload mem[i] = (i ^ (i >> 8)) & 8'hFF at
// time 0 instead of all zeros. Reset never touches mem.
module npu_axi_mem_router #(
    parameter int DATA_W     = 256,
    parameter int ADDR_W     = 64,
    parameter int MEM_ADDR_W = 21
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                m_axi_awvalid,
    output logic                m_axi_awready,
    input  logic [ADDR_W-1:0]   m_axi_awaddr,
    input  logic [7:0]          m_axi_awlen,
    input  logic [2:0]          m_axi_awsize,
    input  logic                m_axi_wvalid,
    output logic                m_axi_wready,
    input  logic [DATA_W-1:0]   m_axi_wdata,
    input  logic [DATA_W/8-1:0] m_axi_wstrb,
    input  logic                m_axi_wlast,
    output logic                m_axi_bvalid,
    input  logic                m_axi_bready,
    input  logic                m_axi_arvalid,
    output logic                m_axi_arready,
    input  logic [ADDR_W-1:0]   m_axi_araddr,
    input  logic [7:0]          m_axi_arlen,
    input  logic [2:0]          m_axi_arsize,
    output logic                m_axi_rvalid,
    input  logic                m_axi_rready,
    output logic [DATA_W-1:0]   m_axi_rdata,
    output logic                m_axi_rlast
);
    localparam int STRB_W    = DATA_W / 8;
    localparam int MEM_DEPTH = 1 << MEM_ADDR_W;

    typedef logic [7:0] mem_t [MEM_DEPTH];

`ifdef AXI_MEM_INIT_PATTERN_EN
    function automatic mem_t mem_init();
        mem_t m;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            m[i] = 8'(i ^ (i >> 8));
        end
        return m;
    endfunction
    mem_t mem = mem_init();
`else
    mem_t mem = '{default: 8'h00};
`endif

    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_e;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_e;

    w_state_e              w_state_q, w_state_d;
    logic                  awready_q, awready_d, wready_q, wready_d, bvalid_q, bvalid_d;
    logic [MEM_ADDR_W-1:0] w_addr_q, w_addr_d;
    logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic [2:0]            w_size_q, w_size_d;
    logic                  w_fire_s;

    r_state_e              r_state_q, r_state_d;
    logic                  arready_q, arready_d, rvalid_q, rvalid_d, rlast_q, rlast_d;
    logic [MEM_ADDR_W-1:0] r_addr_q, r_addr_d;
    logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [2:0]            r_size_q, r_size_d;
    logic [DATA_W-1:0]     rdata_s;

    // Upper address bits are deliberately ignored by the decode.
    logic unused_s;
    assign unused_s = ^{m_axi_awaddr[ADDR_W-1:MEM_ADDR_W], m_axi_araddr[ADDR_W-1:MEM_ADDR_W]};

    assign w_fire_s = (w_state_q == W_DATA) && wready_q && m_axi_wvalid;

    // Write FSM next state: address accept, data beats until len or wlast, then one response.
    always_comb begin
        w_state_d = w_state_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        w_addr_d  = w_addr_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_size_d  = w_size_q;
        case (w_state_q)
            W_IDLE: begin
                if (m_axi_awvalid && awready_q) begin
                    w_addr_d  = m_axi_awaddr[MEM_ADDR_W-1:0];
                    w_len_d   = m_axi_awlen;
                    w_size_d  = m_axi_awsize;
                    w_cnt_d   = 8'd0;
                    awready_d = 1'b0;
                    wready_d  = 1'b1;
                    w_state_d = W_DATA;
                end else begin
                    awready_d = 1'b1;
                end
            end
            W_DATA: begin
                if (w_fire_s) begin
                    if ((w_cnt_q == w_len_q) || m_axi_wlast) begin
                        wready_d  = 1'b0;
                        bvalid_d  = 1'b1;
                        w_state_d = W_RESP;
                    end else begin
                        w_cnt_d  = w_cnt_q + 8'd1;
                        w_addr_d = w_addr_q + (MEM_ADDR_W'(1) << w_size_q);
                    end
                end else begin
                    wready_d = 1'b1;
                end
            end
            W_RESP: begin
                if (bvalid_q && m_axi_bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    w_state_d = W_IDLE;
                end else begin
                    bvalid_d = 1'b1;
                end
            end
            default: begin
                awready_d = 1'b0;
                wready_d  = 1'b0;
                bvalid_d  = 1'b0;
                w_state_d = W_IDLE;
            end
        endcase
    end

    // Write FSM registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            w_addr_q  <= '0;
            w_len_q   <= 8'd0;
            w_cnt_q   <= 8'd0;
            w_size_q  <= 3'd0;
        end else begin
            w_state_q <= w_state_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            w_addr_q  <= w_addr_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_size_q  <= w_size_d;
        end
    end

    // Commit strobed lanes of an accepted beat at byte offset k; index wraps with MEM_ADDR_W.
    always_ff @(posedge clk) begin
        for (int k = 0; k < STRB_W; k++) begin
            if (w_fire_s && m_axi_wstrb[k]) begin
                mem[w_addr_q + MEM_ADDR_W'(k)] <= m_axi_wdata[8*k +: 8];
            end
        end
    end

    // Read FSM next state: address accept, then one beat per rvalid/rready handshake.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rlast_d   = rlast_q;
        r_addr_d  = r_addr_q;
        r_len_d   = r_len_q;
        r_cnt_d   = r_cnt_q;
        r_size_d  = r_size_q;
        case (r_state_q)
            R_IDLE: begin
                if (m_axi_arvalid && arready_q) begin
                    r_addr_d  = m_axi_araddr[MEM_ADDR_W-1:0];
                    r_len_d   = m_axi_arlen;
                    r_size_d  = m_axi_arsize;
                    r_cnt_d   = 8'd0;
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    rlast_d   = (m_axi_arlen == 8'd0);
                    r_state_d = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (rvalid_q && m_axi_rready) begin
                    if (rlast_q) begin
                        rvalid_d  = 1'b0;
                        rlast_d   = 1'b0;
                        arready_d = 1'b1;
                        r_state_d = R_IDLE;
                    end else begin
                        r_cnt_d  = r_cnt_q + 8'd1;
                        r_addr_d = r_addr_q + (MEM_ADDR_W'(1) << r_size_q);
                        rlast_d  = ((r_cnt_q + 8'd1) == r_len_q);
                    end
                end else begin
                    rvalid_d = 1'b1;
                end
            end
            default: begin
                arready_d = 1'b0;
                rvalid_d  = 1'b0;
                rlast_d   = 1'b0;
                r_state_d = R_IDLE;
            end
        endcase
    end

    // Read FSM registers; reset abandons any burst in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            r_addr_q  <= '0;
            r_len_q   <= 8'd0;
            r_cnt_q   <= 8'd0;
            r_size_q  <= 3'd0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
            r_addr_q  <= r_addr_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_size_q  <= r_size_d;
        end
    end

    // Read data follows the current beat index combinationally, so a same-cycle write is not yet visible.
    always_comb begin
        rdata_s = '0;
        for (int k = 0; k < STRB_W; k++) begin
            if (rvalid_q) begin
                rdata_s[8*k +: 8] = mem[r_addr_q + MEM_ADDR_W'(k)];
            end else begin
                rdata_s[8*k +: 8] = 8'h00;
            end
        end
    end

    assign m_axi_awready = awready_q;
    assign m_axi_wready  = wready_q;
    assign m_axi_bvalid  = bvalid_q;
    assign m_axi_arready = arready_q;
    assign m_axi_rvalid  = rvalid_q;
    assign m_axi_rlast   = rlast_q;
    assign m_axi_rdata   = rdata_s;
endmodule

// File: tb/tb_npu_axi_mem_router.sv
// Directed self-checking bench for npu_axi_mem_router (default build: mem starts at zero).
module tb_npu_axi_mem_router;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         m_axi_awvalid = 1'b0, m_axi_awready;
    logic [63:0]  m_axi_awaddr = 64'd0;
    logic [7:0]   m_axi_awlen = 8'd0;
    logic [2:0]   m_axi_awsize = 3'd0;
    logic         m_axi_wvalid = 1'b0, m_axi_wready;
    logic [255:0] m_axi_wdata = 256'd0;
    logic [31:0]  m_axi_wstrb = 32'd0;
    logic         m_axi_wlast = 1'b0;
    logic         m_axi_bvalid, m_axi_bready = 1'b0;
    logic         m_axi_arvalid = 1'b0, m_axi_arready;
    logic [63:0]  m_axi_araddr = 64'd0;
    logic [7:0]   m_axi_arlen = 8'd0;
    logic [2:0]   m_axi_arsize = 3'd0;
    logic         m_axi_rvalid, m_axi_rready = 1'b0;
    logic [255:0] m_axi_rdata;
    logic         m_axi_rlast;

    int errors = 0;
    int checks = 0;
    int b_cnt  = 0;

    npu_axi_mem_router dut (
        .clk(clk), .rst_n(rst_n),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready), .m_axi_awaddr(m_axi_awaddr),
        .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
        .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_wdata(m_axi_wdata),
        .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready), .m_axi_araddr(m_axi_araddr),
        .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
        .m_axi_rlast(m_axi_rlast)
    );

    always #5 clk = ~clk;

    // Count accepted write responses.
    always @(posedge clk) begin
        if (m_axi_bvalid && m_axi_bready) b_cnt <= b_cnt + 1;
    end

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 7) + 3);
    endfunction

    // mode 0: beat number in every byte; mode 1: source pattern; other: byte k = mode + k.
    function automatic logic [255:0] beat_data(input int mode, input int src_base, input int b);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 32; k++) begin
            case (mode)
                0:       d[8*k +: 8] = 8'(b);
                1:       d[8*k +: 8] = pat(src_base + (b * 32) + k);
                default: d[8*k +: 8] = 8'(mode + k);
            endcase
        end
        return d;
    endfunction

    task automatic axi_write(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] strb,
                             input int mode, input int src_base, input int nbeats, input int last_idx,
                             input int bdelay);
        int n;
        int b_before;
        b_before = b_cnt;
        m_axi_awvalid = 1'b1; m_axi_awaddr = addr; m_axi_awlen = len; m_axi_awsize = 3'd5;
        n = 0;
        while (!m_axi_awready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (m_axi_awready !== 1'b1) begin
            errors++; $display("FAIL aw_handshake: awready=%b required 1", m_axi_awready);
        end
        @(negedge clk);
        m_axi_awvalid = 1'b0;
        for (int b = 0; b < nbeats; b++) begin
            m_axi_wvalid = 1'b1; m_axi_wdata = beat_data(mode, src_base, b);
            m_axi_wstrb = strb; m_axi_wlast = (b == last_idx);
            n = 0;
            while (!m_axi_wready && n < 100) begin @(negedge clk); n++; end
            checks++;
            if (m_axi_wready !== 1'b1) begin
                errors++; $display("FAIL w_beat%0d: wready=%b required 1", b, m_axi_wready);
            end
            @(negedge clk);
        end
        m_axi_wvalid = 1'b0; m_axi_wlast = 1'b0;
        checks++;
        if ({m_axi_wready, m_axi_bvalid} !== 2'b01) begin
            errors++; $display("FAIL w_exit: wready,bvalid=%b required 01", {m_axi_wready, m_axi_bvalid});
        end
        for (int i = 0; i < bdelay; i++) begin
            @(negedge clk);
            checks++;
            if (m_axi_bvalid !== 1'b1) begin
                errors++; $display("FAIL b_hold: bvalid=%b required 1", m_axi_bvalid);
            end
        end
        m_axi_bready = 1'b1;
        @(negedge clk);
        m_axi_bready = 1'b0;
        checks++;
        if ({m_axi_bvalid, m_axi_awready} !== 2'b01) begin
            errors++; $display("FAIL b_done: bvalid,awready=%b required 01", {m_axi_bvalid, m_axi_awready});
        end
        checks++;
        if (b_cnt !== b_before + 1) begin
            errors++; $display("FAIL b_count: responses=%0d required %0d", b_cnt - b_before, 1);
        end
    endtask

    task automatic axi_read(input logic [63:0] addr, input logic [7:0] len, input int src_base,
                            input bit toggle);
        int n;
        int beat;
        int cyc;
        logic [255:0] exp;
        m_axi_arvalid = 1'b1; m_axi_araddr = addr; m_axi_arlen = len; m_axi_arsize = 3'd5;
        n = 0;
        while (!m_axi_arready && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (m_axi_arready !== 1'b1) begin
            errors++; $display("FAIL ar_handshake: arready=%b required 1", m_axi_arready);
        end
        @(negedge clk);
        m_axi_arvalid = 1'b0;
        beat = 0; cyc = 0;
        while (beat <= int'(len) && cyc < 2000) begin
            exp = beat_data(1, src_base, beat);
            checks++;
            if (m_axi_rvalid !== 1'b1 || m_axi_rdata !== exp || m_axi_rlast !== (beat == int'(len))) begin
                errors++;
                $display("FAIL r_beat%0d: rvalid=%b rlast=%b rdata=%h required rvalid=1 rlast=%b rdata=%h",
                         beat, m_axi_rvalid, m_axi_rlast, m_axi_rdata, (beat == int'(len)), exp);
            end
            m_axi_rready = toggle ? ((cyc % 2) == 0) : 1'b1;
            if (m_axi_rready) beat++;
            @(negedge clk);
            cyc++;
        end
        m_axi_rready = 1'b0;
        checks++;
        if ({m_axi_rvalid, m_axi_arready, m_axi_rlast} !== 3'b010) begin
            errors++; $display("FAIL r_done: rvalid,arready,rlast=%b required 010",
                               {m_axi_rvalid, m_axi_arready, m_axi_rlast});
        end
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        checks++;
        if ({m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} !== 6'b0
            || m_axi_rdata !== 256'd0) begin
            errors++; $display("FAIL reset_outputs: flags=%b rdata=%h required 0",
                {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast}, m_axi_rdata);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_axi_awready, m_axi_arready} !== 2'b11) begin
            errors++; $display("FAIL reset_release: awready,arready=%b required 11", {m_axi_awready, m_axi_arready});
        end
    endtask

    task automatic test_write_burst();
        int bad;
        int first;
        axi_write(64'h0000_0030_0010_0000, 8'd3, 32'hFFFF_FFFF, 0, 0, 4, 3, 3);
        bad = 0; first = -1;
        for (int j = 0; j < 129; j++) begin
            if (dut.mem[32'h10_0000 + j] !== ((j < 128) ? 8'(j / 32) : 8'h00)) begin
                bad++; if (first < 0) first = j;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL write_burst_mem: %0d bad bytes (first offset %0d) required 0", bad, first);
        end
    endtask

    task automatic test_partial_strobe();
        int bad;
        axi_write(64'h40, 8'd0, 32'h0000_000F, 8'hA0, 0, 1, 0, 0);
        bad = 0;
        for (int j = 'h38; j < 'h68; j++) begin
            if (dut.mem[j] !== ((j >= 'h40 && j < 'h44) ? 8'(8'hA0 + j - 'h40) : 8'h00)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL partial_strobe: %0d bad bytes required 0", bad);
        end
    endtask

    task automatic test_early_wlast();
        int bad;
        axi_write(64'h2000, 8'd3, 32'hFFFF_FFFF, 0, 0, 2, 1, 0);
        bad = 0;
        for (int j = 0; j < 128; j++) begin
            if (dut.mem[32'h2000 + j] !== ((j < 32) ? 8'h00 : (j < 64) ? 8'h01 : 8'h00)) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL early_wlast_mem: %0d bad bytes required 0", bad);
        end
    endtask

    task automatic test_read_burst();
        axi_write(64'h0, 8'd127, 32'hFFFF_FFFF, 1, 0, 128, 127, 0);
        axi_read(64'h0000_0030_0000_0000, 8'd3, 0, 1'b1);
    endtask

    task automatic test_concurrent_copy();
        int bad;
        int first;
        fork
            axi_write(64'h10_0000, 8'd127, 32'hFFFF_FFFF, 1, 0, 128, 127, 2);
            axi_read(64'h0, 8'd127, 0, 1'b0);
        join
        bad = 0; first = -1;
        for (int j = 0; j < 4096; j++) begin
            if (dut.mem[32'h10_0000 + j] !== pat(j) || dut.mem[j] !== pat(j)) begin
                bad++; if (first < 0) first = j;
            end
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL copy_mem: %0d bad bytes (first %0d) required 0", bad, first);
        end
    endtask

    task automatic test_wrap();
        int bad;
        axi_write(64'hFF00_0000_001F_FFF0, 8'd0, 32'hFFFF_FFFF, 8'h50, 0, 1, 0, 0);
        bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (dut.mem[32'h1F_FFF0 + k] !== 8'(8'h50 + k)) bad++;
            if (dut.mem[k] !== 8'(8'h60 + k)) bad++;
        end
        if (dut.mem[16] !== pat(16)) bad++;
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL wrap_mem: %0d bad bytes required 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_partial_strobe();
        test_early_wlast();
        test_read_burst();
        test_concurrent_copy();
        test_wrap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/npu_axi_mem_router.md
Name: npu_axi_mem_router

Overview:
- Behavioural AXI4-subset slave memory model for NPU shell simulation.
- Terminates the NPU AXI master port (DMA shim traffic).
- Maps the low MEM_ADDR_W bits of every AXI address onto one byte array named mem. Benches read and compare that array hierarchically.
- Supports independent single-outstanding write and read INCR bursts.

Parameters:
- DATA_W, 256, AXI data width in bits; must be a multiple of 8.
- ADDR_W, 64, AXI address width.
- MEM_ADDR_W, 21, byte-index width; mem depth is 2**MEM_ADDR_W bytes (2 MiB).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- m_axi_awvalid  in  1  write address valid
- m_axi_awready  out  1  write address ready
- m_axi_awaddr  in  ADDR_W  write burst start byte address
- m_axi_awlen  in  8  beats minus 1
- m_axi_awsize  in  3  log2 bytes per beat
- m_axi_wvalid  in  1  write data valid
- m_axi_wready  out  1  write data ready
- m_axi_wdata  in  DATA_W  write data, byte 0 in bits [7:0]
- m_axi_wstrb  in  DATA_W/8  byte enables
- m_axi_wlast  in  1  last write beat
- m_axi_bvalid  out  1  write response valid (always OKAY; no bresp port)
- m_axi_bready  in  1  write response ready
- m_axi_arvalid  in  1  read address valid
- m_axi_arready  out  1  read address ready
- m_axi_araddr  in  ADDR_W  read burst start byte address
- m_axi_arlen  in  8  beats minus 1
- m_axi_arsize  in  3  log2 bytes per beat
- m_axi_rvalid  out  1  read data valid
- m_axi_rready  in  1  read data ready
- m_axi_rdata  out  DATA_W  read data
- m_axi_rlast  out  1  last read beat

Behaviour:
- Single clock, clk. Asynchronous active-low reset rst_n.
- Reset values: awready=0, wready=0, bvalid=0, arready=0, rvalid=0, rlast=0, rdata=0. Both FSMs enter IDLE.
- Reset does not clear mem. Reset mid-burst abandons the burst with no partial response.
- Address decode:
  - Byte index = addr[MEM_ADDR_W-1:0]; upper address bits are ignored.
  - Example: 0x30_0010_0000 maps to index 0x100000.
  - Index arithmetic wraps modulo 2**MEM_ADDR_W.
- Burst type: INCR only. Beat address advances by (1<<size) bytes per beat. No 4 KiB boundary checking.
- Write FSM (W_IDLE, W_DATA, W_RESP), registered:
  - W_IDLE: awready=1. On awvalid&&awready, latch addr/len/size, clear beat count, go to W_DATA, drop awready.
  - W_DATA: wready=1. On each wvalid&&wready, write mem[idx+k]=wdata[8k+:8] for every k < DATA_W/8 with wstrb[k]=1. Strobed lanes are taken at byte offset k from the beat address; no lane rotation.
  - W_DATA exit: burst ends when the beat count reaches len OR wlast=1, whichever comes first. Then wready=0 and go to W_RESP. Any mismatch between wlast and len is ignored.
  - W_RESP: bvalid=1 until bready is sampled high. Then return to W_IDLE; awready is 1 again on the next cycle.
- Read FSM (R_IDLE, R_DATA), independent of the write FSM:
  - R_IDLE: arready=1. On arvalid&&arready, latch addr/len/size, go to R_DATA.
  - R_DATA: rvalid=1. rdata byte k = mem[beat_idx+k] for k < DATA_W/8, driven combinationally from the current beat index. rlast=1 when beat count == len.
  - On rvalid&&rready, advance to the next beat. When rlast is accepted, return to R_IDLE.
- Simultaneous read and write to the same byte: write commits at the clock edge. A read beat presented in that cycle shows the pre-write value.
- No back-pressure beyond the FSMs: ready signals never depend combinationally on valid.
- len=0: exactly one beat. size may be smaller than DATA_W/8; wstrb still governs which bytes are written.

Optional Feature:
- Macro AXI_MEM_INIT_PATTERN_EN.
- Defined: at time 0, mem[i] = (i ^ (i>>8)) & 8'hFF for all i. Source regions then carry a known non-zero pattern.
- Undefined: mem is initialised to all zeros.
- Initialisation is never redone by reset.

Test Plan:
- Reset: hold rst_n=0 for 4 cycles -> all outputs 0. One cycle after release, awready=1 and arready=1.
- Write burst: AW addr 0x30_0010_0000, len=3, size=5; 4 beats with wdata=beat number replicated per byte and wstrb all-ones, wlast on beat 4 -> mem[0x100000..0x10007F] hold 00/01/02/03 per 32-byte block. One bvalid, held until bready.
- Partial strobe: write addr 0x40, wstrb=32'h0000_000F -> only mem[0x40..0x43] change.
- Read burst: AR addr 0x30_0000_0000, len=3, size=5; rready toggled 1/0 -> 4 beats matching mem[0x0..0x7F]. rlast only on beat 4. Data is stable while rready=0.
- Concurrent copy: read from 0x0 and write to 0x100000 concurrently, 128 beats (4 KiB) -> mem[0x100000+j]==mem[j] for j<4096. Exactly one bvalid.
- Wrap: write at index 0x1FFFF0, 32-byte beat -> bytes land at 0x1FFFF0..0x1FFFFF and 0x0..0xF.
